// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths and PC alignment helper for the fetch unit
package inst_fetch_unit_pkg;
  localparam int INST_ADD_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  function automatic logic misaligned(input logic [1:0] lo);
    return |lo;
  endfunction
endpackage

// File: rtl/inst_fetch_unit_fetch_wait_timer.sv
// inst_fetch_unit_fetch_wait_timer: memory-wait counter with terminal count at WAIT_LIMIT-1
// clk_i/rst_ni clock and async active-low reset; clr_i zeroes the count;
// en_i counts one waiting cycle; tc_o flags the last allowed waiting cycle.
module inst_fetch_unit_fetch_wait_timer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [W-1:0] TC = W'(WAIT_LIMIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = (cnt_q == TC);
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-cycle instruction fetch between PC and a handshaked instruction memory
// In:  clk_i, rst_ni, pc_i, fetch_en_i, flush_i, err_clr_i, mem_ack_i, mem_rdata_i, inst_ready_i
// Out: mem_req_o, mem_addr_o, inst_o, pc_out_o, inst_valid_o, busy_o, fetch_err_o
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = INST_ADD_WIDTH,
  parameter int DATA_W = INST_WIDTH,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              fetch_en_i,
  input  logic              flush_i,
  input  logic              err_clr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              busy_o,
  output logic              fetch_err_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HOLD} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] addr_q, pc_out_q;
  logic [DATA_W-1:0] inst_q;
  logic err_q, waiting, tc, timeout, accept, start, bad_pc;
  assign waiting = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign timeout = waiting && tc && !mem_ack_i;
  assign accept = !flush_i && fetch_en_i && ((state_q == S_IDLE) || (state_q == S_HOLD && inst_ready_i));
  assign bad_pc = accept && misaligned(pc_i[1:0]);
  assign start = accept && !bad_pc;
  inst_fetch_unit_fetch_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (start),
    .en_i  (waiting),
    .tc_o  (tc)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      pc_out_q <= '0;
      inst_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (bad_pc || timeout) ? 1'b1 : err_clr_i ? 1'b0 : err_q;
      if (start) addr_q <= pc_i;
      case (state_q)
        S_IDLE: if (start) state_q <= S_REQ;
        S_REQ: begin
          if (mem_ack_i && !flush_i) begin
            inst_q   <= mem_rdata_i;
            pc_out_q <= addr_q;
            state_q  <= S_HOLD;
          end else if (mem_ack_i || timeout) state_q <= S_IDLE;
          else if (flush_i) state_q <= S_DRAIN;
        end
        S_DRAIN: if (mem_ack_i || timeout) state_q <= S_IDLE;
        default: if (flush_i || inst_ready_i) state_q <= start ? S_REQ : S_IDLE;
      endcase
    end
  end
  assign mem_req_o    = waiting;
  assign mem_addr_o   = addr_q;
  assign inst_o       = inst_q;
  assign pc_out_o     = pc_out_q;
  assign inst_valid_o = (state_q == S_HOLD);
  assign busy_o       = (state_q != S_IDLE);
  assign fetch_err_o  = err_q;
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Multi-cycle instruction fetch responder sitting between the program counter and a handshaked instruction memory. It takes the current PC, issues a held request to memory, captures the returned word, and presents it to the decoder with a valid/ready handshake until consumed. Supports flush of in-flight fetches, a memory-wait timeout, and misaligned-PC detection.

## Interface
- `ADDR_W`, default `INST_ADD_WIDTH`: PC/memory address width.
- `DATA_W`, default 32: instruction width.
- `WAIT_LIMIT`, default 255: maximum cycles `MEM_REQ` stays high without `MEM_ACK` (≥1).
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- PC  in  ADDR_W  address to fetch; sampled only when a fetch is accepted.
- FETCH_EN  in  1  request a fetch of `PC`.
- FLUSH  in  1  discard pending or held instruction.
- ERR_CLR  in  1  clears `FETCH_ERR`.
- MEM_REQ  out  1  memory request, held until ACK or timeout.
- MEM_ADDR  out  ADDR_W  request address, stable while `MEM_REQ`=1.
- MEM_ACK  in  1  memory returns data this cycle.
- MEM_RDATA  in  DATA_W  returned word, valid with `MEM_ACK`.
- INST  out  DATA_W  fetched instruction.
- PC_OUT  out  ADDR_W  address of `INST`.
- INST_VALID  out  1  `INST`/`PC_OUT` valid.
- INST_READY  in  1  decoder accepts.
- BUSY  out  1  state ≠ IDLE.
- FETCH_ERR  out  1  sticky error: timeout or misaligned PC.

## Operation
- States: IDLE, REQ, DRAIN, HOLD. Reset → IDLE. All outputs 0, wait counter 0.
- IDLE: if `FLUSH`=1, do nothing (flush wins over `FETCH_EN`). Otherwise, on `FETCH_EN`=1:
  - if `PC[1:0]`≠0, set `FETCH_ERR` and stay IDLE;
  - else latch `PC` into `MEM_ADDR` and go to REQ.
- REQ: `MEM_REQ`=1.
  - `MEM_ACK` with no `FLUSH`: capture `MEM_RDATA` into `INST`, copy `MEM_ADDR` into `PC_OUT`, go to HOLD.
  - `MEM_ACK` with `FLUSH`: discard the data, go to IDLE.
  - `FLUSH` without `MEM_ACK`: go to DRAIN.
- DRAIN: `MEM_REQ`=1. On `MEM_ACK`, discard the data and go to IDLE. `FLUSH` has no further effect.
- Timeout applies in REQ and DRAIN:
  - The counter clears on entry and increments each cycle without `MEM_ACK`.
  - If the counter = `WAIT_LIMIT`-1 and there is no `MEM_ACK`, set `FETCH_ERR` and go to IDLE. `MEM_REQ` is therefore high for exactly `WAIT_LIMIT` cycles.
  - A late `MEM_ACK` arriving in IDLE is ignored.
- HOLD: `INST_VALID`=1; `INST` and `PC_OUT` are held stable.
  - `FLUSH`: go to IDLE. It has priority over `INST_READY`.
  - `INST_READY`=1 with `FETCH_EN`=1: accept the next fetch exactly as in IDLE (including the misalignment check), going to REQ.
  - `INST_READY`=1 with `FETCH_EN`=0: go to IDLE.
- `FETCH_EN` is ignored in REQ and DRAIN, and in HOLD without `INST_READY`.
- `FETCH_ERR`: set-dominant over `ERR_CLR` in the same cycle. It does not block further fetches.
- `INST` and `PC_OUT` keep their last values outside HOLD. `MEM_ADDR` keeps its last value outside REQ/DRAIN.

## Timing
- All outputs are registered or decoded from state only. There is no combinational input→output path.
- `FETCH_EN` sampled at edge 0 → `MEM_REQ`=1 after edge 0.
- `MEM_ACK` sampled at edge k → `INST_VALID`=1 after edge k and `MEM_REQ`=0 after edge k.
- Minimum fetch latency is 2 cycles, `FETCH_EN` to `INST_VALID`.
- Peak throughput is one instruction per 2 cycles (HOLD→REQ→HOLD with a 1-cycle ACK).
- Asserting `RST` mid-operation forces IDLE and zeroes outputs immediately. An in-flight memory request is abandoned.

## Structure
- Shared constants come from `MACROS.v`: `INST_ADD_WIDTH`, and `INST_WIDTH` (add it if absent).
- State encodings are local to the module (2-bit).
- Natural sub-module: `fetch_wait_timer`, holding the counter, clear and terminal-count logic, parameterised by `WAIT_LIMIT`.
- Everything else lives in a single always block for the FSM plus registered datapath.

## Test plan
- **Reset/basic:** release `RST`, `PC`=0x00400000, `FETCH_EN` one cycle; `MEM_ACK` on the 3rd REQ cycle with 0x20080005.
  - Required: `INST_VALID` rises the next cycle, `INST`=0x20080005, `PC_OUT`=0x00400000, `MEM_REQ` drops together with the `INST_VALID` rise.
- **Backpressure/back-to-back:** hold `INST_READY`=0 for 5 cycles, then `INST_READY`=1 with `FETCH_EN`=1 and `PC`=0x00400004.
  - Required: `INST` stable throughout; `MEM_REQ`=1 with `MEM_ADDR`=0x00400004 the next cycle.
- **Flush in REQ:** assert `FLUSH` at REQ cycle 1, then `MEM_ACK` at cycle 4 with 0xDEADBEEF.
  - Required: state passes through DRAIN, `INST_VALID` never rises, `BUSY`=0 after the ACK.
- **Timeout:** `WAIT_LIMIT`=4, never ACK.
  - Required: `MEM_REQ` high for exactly 4 cycles, then `FETCH_ERR`=1. `ERR_CLR` then clears it; a late ACK in IDLE has no effect.
- **Misaligned PC:** `PC`=0x00400002 with `FETCH_EN`.
  - Required: `MEM_REQ` stays 0, `FETCH_ERR`=1 next cycle.
- **Reset mid-HOLD and FLUSH+FETCH_EN in IDLE:**
  - `RST` low during HOLD → all outputs 0 immediately.
  - `FLUSH` and `FETCH_EN` together in IDLE → no request issued.
